// File: rtl/window_gen_3x3_pkg.sv
// window_gen_3x3_pkg
// Shared defaults and helpers for the 3x3 sliding-window generator.
// Contents:
//   DEF_DATA_WIDTH / DEF_FRAC_BITS  : fixed-point pixel format of the CNN datapath
//   DEF_IMG_WIDTH / DEF_IMG_HEIGHT  : default frame geometry
//   emit_pos()                      : decides whether a pixel position completes
//                                     a window that must be emitted
// Optional feature macro: WINGEN_STRIDE2_EN (emit only every other window
// in both directions).
package window_gen_3x3_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_FRAC_BITS  = 8;
  localparam int unsigned DEF_IMG_WIDTH  = 28;
  localparam int unsigned DEF_IMG_HEIGHT = 28;
  localparam int unsigned WIN_TAPS       = 9;

  // The pixel at (row, col) is the bottom-right corner of a full 3x3
  // neighbourhood once row >= 2 and col >= 2.  With stride 2 only
  // corners at even offsets from (2,2) are kept; since 2 is even this is
  // simply "row and col even".
  function automatic logic emit_pos(input int unsigned row,
                                    input int unsigned col);
    logic full_win;
    full_win = (row >= 2) && (col >= 2);
`ifdef WINGEN_STRIDE2_EN
    return full_win && (row[0] == 1'b0) && (col[0] == 1'b0);
`else
    return full_win;
`endif
  endfunction

endpackage

// File: rtl/window_gen_3x3_line_buffer.sv
// window_gen_3x3_line_buffer
// One-row delay line: DEPTH entries of WIDTH bits, read and written at the
// same index.  The read is combinational and returns the value stored one
// row earlier; the write of the new value lands on the clock edge.
// Contents are intentionally not reset.
// Ports:
//   clk      : rising-edge clock
//   wr_en_i  : write wdata_i at idx_i this cycle
//   idx_i    : column index
//   wdata_i  : value to store
//   rdata_o  : value currently stored at idx_i
module window_gen_3x3_line_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 28
) (
  input  logic                     clk,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] idx_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[idx_i];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/window_gen_3x3.sv
// window_gen_3x3
// Streaming 3x3 sliding-window generator (valid-only, no padding).
// Accepts a raster-order pixel stream and emits row-major 3x3 windows.
// Optional macro: WINGEN_STRIDE2_EN (stride-2 window emission).
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_ready    : input handshake, in_pixel raster-order pixel
//   out_valid/out_ready  : output handshake for px0..px8
//   px0..px8             : window, px0 top-left, px8 bottom-right (newest)
//   frame_done           : one-cycle pulse after the frame's last pixel
module window_gen_3x3
  import window_gen_3x3_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_pixel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] px0,
  output logic [DATA_WIDTH-1:0] px1,
  output logic [DATA_WIDTH-1:0] px2,
  output logic [DATA_WIDTH-1:0] px3,
  output logic [DATA_WIDTH-1:0] px4,
  output logic [DATA_WIDTH-1:0] px5,
  output logic [DATA_WIDTH-1:0] px6,
  output logic [DATA_WIDTH-1:0] px7,
  output logic [DATA_WIDTH-1:0] px8,
  output logic                  frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic                  out_valid_q, out_valid_d;
  logic                  frame_done_q, frame_done_d;
  logic [DATA_WIDTH-1:0] win_q [WIN_TAPS];
  logic [DATA_WIDTH-1:0] win_d [WIN_TAPS];
  logic [DATA_WIDTH-1:0] lb0_rd, lb1_rd;
  logic [DATA_WIDTH-1:0] col_new [3];
  logic                  xfer, emit;

  // Only stall path: a held, unaccepted window blocks new input.
  assign in_ready = !out_valid_q || out_ready;
  assign xfer     = in_valid && in_ready;
  assign emit     = xfer && emit_pos(32'(row_q), 32'(col_q));

  // lb0 holds row r-1; its old content (row r-2) cascades into lb1.
  window_gen_3x3_line_buffer #(.WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb0 (
    .clk     (clk),
    .wr_en_i (xfer),
    .idx_i   (col_q),
    .wdata_i (in_pixel),
    .rdata_o (lb0_rd)
  );

  window_gen_3x3_line_buffer #(.WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb1 (
    .clk     (clk),
    .wr_en_i (xfer),
    .idx_i   (col_q),
    .wdata_i (lb0_rd),
    .rdata_o (lb1_rd)
  );

  // Incoming right-hand column, top to bottom.
  assign col_new[0] = lb1_rd;
  assign col_new[1] = lb0_rd;
  assign col_new[2] = in_pixel;

  // Every transfer shifts the window left, even non-emitting ones, so by
  // the time col >= 2 all three columns belong to the current row band.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_win_row
      assign win_d[3*gi]     = xfer ? win_q[3*gi+1] : win_q[3*gi];
      assign win_d[3*gi + 1] = xfer ? win_q[3*gi+2] : win_q[3*gi+1];
      assign win_d[3*gi + 2] = xfer ? col_new[gi]   : win_q[3*gi+2];
    end
  endgenerate

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    frame_done_d = 1'b0;
    out_valid_d  = out_valid_q;
    if (xfer) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        frame_done_d = (row_q == ROW_LAST);
      end else begin
        col_d = col_q + 1'b1;
      end
    end
    if (emit) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < WIN_TAPS; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      for (int i = 0; i < WIN_TAPS; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign px0 = win_q[0];
  assign px1 = win_q[1];
  assign px2 = win_q[2];
  assign px3 = win_q[3];
  assign px4 = win_q[4];
  assign px5 = win_q[5];
  assign px6 = win_q[6];
  assign px7 = win_q[7];
  assign px8 = win_q[8];

endmodule

// File: tb/tb_window_gen_3x3.sv
// tb_window_gen_3x3
// Randomized, self-checking bench for window_gen_3x3 against a frame-array
// reference model.  Honours WINGEN_STRIDE2_EN (6x6 frames when defined,
// 4x4 otherwise).
module tb_window_gen_3x3;

`ifdef WINGEN_STRIDE2_EN
  localparam int  IW = 6;
  localparam int  IH = 6;
  localparam bit  STRIDE2 = 1'b1;
`else
  localparam int  IW = 4;
  localparam int  IH = 4;
  localparam bit  STRIDE2 = 1'b0;
`endif
  localparam int  WPF = STRIDE2 ? ((IH - 3) / 2 + 1) * ((IW - 3) / 2 + 1)
                                : (IH - 2) * (IW - 2);
  localparam int  LAST_R = STRIDE2 ? ((IH - 3) / 2) * 2 : IH - 3;
  localparam int  LAST_C = STRIDE2 ? ((IW - 3) / 2) * 2 : IW - 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_pixel;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] px0, px1, px2, px3, px4, px5, px6, px7, px8;
  logic        frame_done;
  logic [143:0] pxvec;

  window_gen_3x3 #(.DATA_WIDTH(16), .IMG_WIDTH(IW), .IMG_HEIGHT(IH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixel   (in_pixel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .px0        (px0),
    .px1        (px1),
    .px2        (px2),
    .px3        (px3),
    .px4        (px4),
    .px5        (px5),
    .px6        (px6),
    .px7        (px7),
    .px8        (px8),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  assign pxvec = {px0, px1, px2, px3, px4, px5, px6, px7, px8};

  int err_cnt = 0;
  int chk_cnt = 0;

  // Reference model state
  logic [15:0]  pix [IH][IW];
  int           idx;
  logic         exp_valid;
  logic         exp_fd;
  logic [143:0] cur_win;

  // Observation log
  logic [143:0] win_log [64];
  int           log_n = 0;
  int           fd_seen = 0;
  int           frames_done = 0;

  task automatic check_eq(input string tag, input logic [143:0] got,
                          input logic [143:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Window with top-left at (r0,c0) of a frame whose pixel (r,c) = base+r*IW+c.
  function automatic logic [143:0] mkwin(input int base, input int r0, input int c0);
    logic [143:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w = {w[127:0], 16'(base + (r0 + i) * IW + c0 + j)};
    return w;
  endfunction

  function automatic bit wants_window(input int r, input int c);
    if (r < 2 || c < 2) return 1'b0;
    if (STRIDE2) return ((r - 2) % 2 == 0) && ((c - 2) % 2 == 0);
    return 1'b1;
  endfunction

  task automatic model_reset();
    idx = 0;
    exp_valid = 1'b0;
    exp_fd = 1'b0;
    cur_win = '0;
  endtask

  // One clock cycle: drive, check against model, advance model, clock.
  task automatic tick(input logic v, input logic [15:0] p, input logic ordy,
                      output logic acc);
    int r, c;
    logic exp_rdy;
    logic [143:0] w;
    in_valid = v;
    in_pixel = p;
    out_ready = ordy;
    #1;
    exp_rdy = !exp_valid || ordy;
    check_eq("in_ready", 144'(in_ready), 144'(exp_rdy));
    check_eq("out_valid", 144'(out_valid), 144'(exp_valid));
    check_eq("frame_done", 144'(frame_done), 144'(exp_fd));
    if (exp_valid) check_eq("window", pxvec, cur_win);
    if (out_valid && ordy) begin
      if (log_n < 64) win_log[log_n] = pxvec;
      log_n++;
    end
    if (frame_done) fd_seen++;
    acc = v && exp_rdy;
    r = idx / IW;
    c = idx % IW;
    exp_fd = acc && (idx == IW * IH - 1);
    if (acc) begin
      pix[r][c] = p;
      idx = (idx + 1) % (IW * IH);
    end
    if (acc && wants_window(r, c)) begin
      w = '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          w = {w[127:0], pix[r - 2 + i][c - 2 + j]};
      cur_win = w;
      exp_valid = 1'b1;
    end else if (ordy) begin
      exp_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_frame(input int base, input bit gaps, input bit rnd_ordy,
                           input bit bp, input bit sgn, input int n_pix);
    int k, cyc, bp_left;
    bit bp_done;
    logic v, ordy, acc;
    logic [15:0] p;
    k = 0; cyc = 0; bp_left = 0; bp_done = 1'b0;
    while (k < n_pix && cyc < 4000) begin
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      ordy = rnd_ordy ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (bp && !bp_done && exp_valid) begin
        bp_left = 3;
        bp_done = 1'b1;
      end
      if (bp_left > 0) begin
        ordy = 1'b0;
        bp_left--;
      end
      if (sgn) p = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h7FFF;
      else     p = 16'(base + k);
      tick(v, p, ordy, acc);
      if (acc) k++;
      cyc++;
    end
    check_eq("frame_accept_count", 144'(k), 144'(n_pix));
    if (n_pix == IW * IH) frames_done++;
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 4; i++) tick(1'b0, 16'h0, 1'b1, acc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_pixel = '0;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    check_eq("rst_out_valid", 144'(out_valid), 144'(0));
    check_eq("rst_frame_done", 144'(frame_done), 144'(0));
    check_eq("rst_in_ready", 144'(in_ready), 144'(1));
    check_eq("rst_px", pxvec, 144'(0));
    $display("reset applied: out_valid=%0b frame_done=%0b", out_valid, frame_done);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_pixel = '0;
    out_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Plain frame 0.., continuous input
    run_frame(0, 1'b0, 1'b0, 1'b0, 1'b0, IW * IH);
    // Same frame with a 3-cycle backpressure burst, then a back-to-back frame 100..
    run_frame(0, 1'b0, 1'b0, 1'b1, 1'b0, IW * IH);
    run_frame(100, 1'b0, 1'b0, 1'b0, 1'b0, IW * IH);
    drain();
    check_eq("frame0_windows", 144'(log_n), 144'(3 * WPF));
    check_eq("first_window", win_log[0], mkwin(0, 0, 0));
    if (WPF > 1) check_eq("second_window", win_log[1],
                          mkwin(0, 0, STRIDE2 ? 2 : 1));
    check_eq("last_window", win_log[WPF - 1], mkwin(0, LAST_R, LAST_C));
    check_eq("bp_first_window", win_log[WPF], mkwin(0, 0, 0));
    check_eq("b2b_first_window", win_log[2 * WPF], mkwin(100, 0, 0));
    check_eq("frame_done_count", 144'(fd_seen), 144'(3));
    $display("directed frames: windows=%0d frame_done=%0d", log_n, fd_seen);

    // Partial frame (pixels 0..9), reset, then a fresh frame
    run_frame(0, 1'b0, 1'b0, 1'b0, 1'b0, 10);
    do_reset();
    run_frame(0, 1'b0, 1'b0, 1'b0, 1'b0, IW * IH);
    drain();
    check_eq("post_reset_windows", 144'(log_n), 144'(4 * WPF));
    check_eq("post_reset_first", win_log[3 * WPF], mkwin(0, 0, 0));
    check_eq("post_reset_last", win_log[4 * WPF - 1], mkwin(0, LAST_R, LAST_C));
    $display("reset-mid-frame: windows=%0d", log_n);

    // Signed extremes with gaps and random backpressure, then random frames
    run_frame(0, 1'b1, 1'b1, 1'b0, 1'b1, IW * IH);
    for (int f = 0; f < 2; f++)
      run_frame(int'($urandom_range(0, 60000)), 1'b1, 1'b1, 1'b0, 1'b0, IW * IH);
    drain();
    check_eq("total_windows", 144'(log_n), 144'(frames_done * WPF));
    check_eq("total_frame_done", 144'(fd_seen), 144'(frames_done));
    $display("random frames: total windows=%0d frames=%0d", log_n, frames_done);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/window_gen_3x3.md
# window_gen_3x3

Streaming 3x3 sliding-window generator that sits in front of `mac_3x3` in the convolution datapath. It accepts a raster-order pixel stream of one IMG_HEIGHT x IMG_WIDTH frame and emits the nine-pixel neighbourhoods `px0..px8` that `mac_3x3` consumes, one window per cycle. It uses valid-only convolution (no padding) and valid/ready handshakes on both sides. Pixels pass through untouched in the fixed-point format from `cnn_params.vh`.

## Interface
Parameters:
- DATA_WIDTH, default `DATA_WIDTH` (16): pixel width, signed fixed point.
- IMG_WIDTH, default 28: pixels per row, minimum 3.
- IMG_HEIGHT, default 28: rows per frame, minimum 3.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  in_pixel is valid.
- in_ready  out  1  block accepts a pixel this cycle.
- in_pixel  in  DATA_WIDTH  signed pixel, raster order.
- out_valid  out  1  px0..px8 hold a valid window.
- out_ready  in  1  downstream accepts the window.
- px0..px8  out  DATA_WIDTH each  window in row-major order: px0 is top-left, px8 is bottom-right (newest pixel).
- frame_done  out  1  one-cycle pulse for the frame's last pixel.

## Operation
- An input transfer occurs when in_valid && in_ready.
- in_ready = !out_valid || out_ready. This is combinational and is the only stall path.
- Counters:
  - col runs 0..IMG_WIDTH-1; row runs 0..IMG_HEIGHT-1.
  - Both advance only on an input transfer.
  - col wraps to 0 and increments row.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1) both wrap to 0, giving back-to-back frames with no idle cycle.
- Storage:
  - Two line buffers, each IMG_WIDTH deep. lb0 holds row r-1 and lb1 holds row r-2, both indexed by col.
  - A 3x3 window register array.
- On each input transfer at (r,c):
  - Shift the window left by one column.
  - The new right column is {lb1[c], lb0[c], in_pixel}, top to bottom.
  - Then lb1[c] <= lb0[c] and lb0[c] <= in_pixel.
- A window is emitted when the transfer has r >= 2 and c >= 2: out_valid is set next cycle with the updated window.
  - Windows from the previous row or frame never leak into an emitted window.
- out_valid and px0..px8 hold stable while out_valid && !out_ready.
- out_valid clears after an output transfer with no new qualifying input.
- Windows per frame: (IMG_HEIGHT-2)*(IMG_WIDTH-2).
- frame_done is asserted the cycle after the transfer of pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
- No arithmetic and no width change: px values are bit-exact copies of input pixels.

## Timing
- Latency is 1 cycle from the qualifying input transfer to out_valid.
- Throughput is 1 pixel per cycle when out_ready stays high.
- An output transfer and a new qualifying input in the same cycle load the new window, and out_valid stays 1.
- Reset values: out_valid=0, frame_done=0, px0..px8=0, col=0, row=0. in_ready is therefore 1 after reset.
  - Line buffer contents are not reset.
- Reset mid-frame discards the partial frame. The next accepted pixel is (0,0).
- With in_valid low, state is frozen; only out_valid can clear, on an output transfer.

## Configuration
- Macro `WINGEN_STRIDE2_EN`.
- Defined: a window is emitted only when (r-2) and (c-2) are both even. Windows per frame: (floor((IMG_HEIGHT-3)/2)+1) * (floor((IMG_WIDTH-3)/2)+1). frame_done is unchanged.
- Undefined: stride 1, as described above.

## Structure
- `cnn_params.vh` gains `IMG_WIDTH` and `IMG_HEIGHT` defaults, alongside the existing `DATA_WIDTH` and `FRAC_BITS`.
- Sub-module `line_buffer`: a DATA_WIDTH x IMG_WIDTH delay line with read and write at the same index. It is instantiated twice.
- Counters, the window array, and the handshake logic live in the top module.

## Test plan
- **Stride 1, 4x4 frame.** Configure IMG_WIDTH=IMG_HEIGHT=4 and feed raw pixels 0..15 with out_ready=1. Required response:
  - Exactly 4 windows.
  - First window is 0,1,2,4,5,6,8,9,10.
  - Second window is 1,2,3,5,6,7,9,10,11.
  - Last window is 5,6,7,9,10,11,13,14,15.
  - frame_done is high exactly once, the cycle after pixel 15.
- **Backpressure.** Same frame; drop out_ready for 3 cycles while out_valid=1. Required response:
  - in_ready=0 for those cycles.
  - The window is held bit-stable.
  - No window is lost or duplicated.
- **Back-to-back frames.** Feed two consecutive 4x4 frames, the second with values 100..115. The second frame's first window is 100,101,102,104,105,106,108,109,110.
- **Reset mid-frame.** Assert rst_n=0 for 1 cycle after pixel 9 of a 4x4 frame. Required response:
  - Next cycle: out_valid=0 and frame_done=0.
  - A fresh frame 0..15 yields exactly the 4 windows from the stride-1 scenario.
- **Signed and gapped input.** Feed pixels -1 (all ones) and 0x7FFF with random in_valid gaps. Window contents are bit-exact, and the window count is unchanged.
- **Stride 2 (`WINGEN_STRIDE2_EN`).** Feed a 6x6 frame of raw pixels 0..35. Required response:
  - Exactly 4 windows.
  - First window is 0,1,2,6,7,8,12,13,14.
  - Last window is 14,15,16,20,21,22,26,27,28.
